// File: rtl/pe_host_seq.sv
// ---------------------------------------------------------------------------
// pe_host_seq
//
// Host-side sequencer for the PE controller's shared-BRAM/start/done
// protocol. It streams 2*VECTOR_SIZE operand words into the shared BRAM
// (global vector first, then local vector), pulses start, waits for done,
// reads the 32-bit result back from word 0 and offers it on a valid/ready
// output. A bounded wait aborts the job and raises a sticky timeout flag.
//
// Ports
//   aclk, areset          clock, synchronous active-high reset
//   in_data/valid/ready   operand word stream (upstream)
//   start, done           one-cycle handshake with the PE controller
//   BRAM_*                this sequencer's port of the shared BRAM
//                         (byte address = {word index, 2'b00}, 1-cycle read)
//   out_data/valid/ready  result word stream (downstream)
//   busy                  high in every state except IDLE
//   timeout_err           sticky abort flag, cleared when a new job begins
// ---------------------------------------------------------------------------
module pe_host_seq #(
  parameter int VECTOR_SIZE = 16,
  parameter int L_RAM_SIZE  = 4,
  parameter int TIMEOUT     = 1024
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        start,
  input  logic        done,
  output logic [31:0] BRAM_ADDR,
  output logic [31:0] BRAM_WRDATA,
  output logic [3:0]  BRAM_WE,
  output logic        BRAM_EN,
  input  logic [31:0] BRAM_RDDATA,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        timeout_err
);

  localparam int WIDX_W = L_RAM_SIZE + 1;
  localparam int CNT_W  = $clog2(TIMEOUT) + 1;

  localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(2 * VECTOR_SIZE - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_READ  = 3'd4,
    S_CAPT  = 3'd5,
    S_OUT   = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [WIDX_W-1:0]   widx_q, widx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         out_data_q, out_data_d;
  logic                terr_q, terr_d;
  logic [WIDX_W-1:0]   addr_word_s;

  // Next-state, datapath updates and all decoded outputs.
  always_comb begin
    state_d     = state_q;
    widx_d      = widx_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    terr_d      = terr_q;
    in_ready    = 1'b0;
    start       = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    addr_word_s = {WIDX_W{1'b0}};
    BRAM_WRDATA = 32'h0000_0000;
    BRAM_WE     = 4'h0;
    BRAM_EN     = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy     = 1'b0;
        in_ready = 1'b1;
        // First operand always lands in word 0 and opens a new job.
        if (in_valid) begin
          BRAM_EN     = 1'b1;
          BRAM_WE     = 4'hF;
          BRAM_WRDATA = in_data;
          addr_word_s = {WIDX_W{1'b0}};
          widx_d      = WIDX_W'(1);
          terr_d      = 1'b0;
          state_d     = S_FILL;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          BRAM_EN     = 1'b1;
          BRAM_WE     = 4'hF;
          BRAM_WRDATA = in_data;
          addr_word_s = widx_q;
          if (widx_q == LAST_IDX) begin
            widx_d  = {WIDX_W{1'b0}};
            state_d = S_START;
          end else begin
            widx_d  = widx_q + WIDX_W'(1);
            state_d = S_FILL;
          end
        end else begin
          state_d = S_FILL;
        end
      end

      S_START: begin
        start   = 1'b1;
        cnt_d   = {CNT_W{1'b0}};
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // done takes priority over an expiry in the same cycle.
        if (done) begin
          state_d = S_READ;
        end else if (cnt_q == CNT_LAST) begin
          terr_d  = 1'b1;
          cnt_d   = {CNT_W{1'b0}};
          state_d = S_IDLE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_WAIT;
        end
      end

      S_READ: begin
        BRAM_EN     = 1'b1;
        addr_word_s = {WIDX_W{1'b0}};
        state_d     = S_CAPT;
      end

      S_CAPT: begin
        // Read data from the READ cycle is valid now (1-cycle BRAM latency).
        out_data_d = BRAM_RDDATA;
        state_d    = S_OUT;
      end

      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_OUT;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign BRAM_ADDR   = {{(30 - WIDX_W){1'b0}}, addr_word_s, 2'b00};
  assign out_data    = out_data_q;
  assign timeout_err = terr_q;

  // State, index, wait counter, result and error flag registers.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= S_IDLE;
      widx_q     <= {WIDX_W{1'b0}};
      cnt_q      <= {CNT_W{1'b0}};
      out_data_q <= 32'h0000_0000;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      widx_q     <= widx_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      terr_q     <= terr_d;
    end
  end

endmodule

// File: tb/tb_pe_host_seq.sv
// ---------------------------------------------------------------------------
// tb_pe_host_seq
//
// Self-checking bench for pe_host_seq (TIMEOUT reduced to 8). A small BRAM
// model and a PE-controller model surround the DUT; expected values come
// from the words the bench sends, the result it plants and the protocol's
// cycle rules.
// ---------------------------------------------------------------------------
module tb_pe_host_seq;

  localparam int VS = 16;
  localparam int NW = 2 * VS;
  localparam int TO = 8;

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        start;
  logic        done;
  logic [31:0] BRAM_ADDR;
  logic [31:0] BRAM_WRDATA;
  logic [3:0]  BRAM_WE;
  logic        BRAM_EN;
  logic [31:0] BRAM_RDDATA;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        timeout_err;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [NW];
  logic [31:0] exp_words [NW];
  logic        pe_we;
  logic [31:0] pe_wdata;
  int          wr_count = 0;
  int          spurious = 0;
  int          start_count = 0;

  pe_host_seq #(.VECTOR_SIZE(VS), .L_RAM_SIZE(4), .TIMEOUT(TO)) dut (
    .aclk(aclk), .areset(areset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .start(start), .done(done),
    .BRAM_ADDR(BRAM_ADDR), .BRAM_WRDATA(BRAM_WRDATA), .BRAM_WE(BRAM_WE),
    .BRAM_EN(BRAM_EN), .BRAM_RDDATA(BRAM_RDDATA),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 aclk = ~aclk;

  // Shared BRAM (read-first, 1-cycle latency) plus protocol monitors.
  always @(posedge aclk) begin
    if (pe_we) mem[0] <= pe_wdata;
    if (BRAM_EN) begin
      if (BRAM_WE == 4'hF) begin
        mem[BRAM_ADDR[6:2]] <= BRAM_WRDATA;
        wr_count <= wr_count + 1;
      end
      BRAM_RDDATA <= mem[BRAM_ADDR[6:2]];
    end
    if (((BRAM_WE != 4'h0) && !(in_valid && in_ready && BRAM_EN)) ||
        (BRAM_ADDR[31:7] != 25'h0) ||
        ((BRAM_WE != 4'h0) && (BRAM_WE != 4'hF)))
      spurious <= spurious + 1;
    if (start) start_count <= start_count + 1;
  end

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // mode 0: full rate, 1: valid every other cycle, 2: random gaps.
  // Returns at the negedge inside the START cycle.
  task automatic fill(input int mode, input bit stray);
    int idx = 0;
    int cyc = 0;
    int wc0 = wr_count;
    int sc0 = start_count;
    int bad = 0;
    bit v;
    bit first_chk = 1'b0;
    while (idx < NW) begin
      @(negedge aclk);
      if (idx > 0 && !first_chk) begin
        chk1("terr_cleared_on_accept", timeout_err, 1'b0);
        chk1("busy_in_fill", busy, 1'b1);
        first_chk = 1'b1;
      end
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 1) == 1);
      endcase
      in_valid = v;
      in_data  = v ? exp_words[idx] : $urandom;
      done     = stray && !v;
      if (v) idx++;
      cyc++;
    end
    @(negedge aclk);
    in_valid = 1'b0;
    done     = 1'b0;
    chk1("start_after_last_word", start, 1'b1);
    chk1("in_ready_low_in_start", in_ready, 1'b0);
    chk32("no_early_start", 32'(start_count - sc0), 32'd0);
    chk32("write_count", 32'(wr_count - wc0), 32'(NW));
    for (int i = 0; i < NW; i++) if (mem[i] !== exp_words[i]) bad++;
    chk32("bram_contents_bad_words", 32'(bad), 32'd0);
    chk32("spurious_bram_activity", 32'(spurious), 32'd0);
  endtask

  // From START: done in WAIT cycle d, result res, out_ready held low hold cycles.
  task automatic finish_job(input int d, input logic [31:0] res, input int hold);
    int sc0 = start_count;
    for (int k = 0; k <= d; k++) begin
      @(negedge aclk);
      if (k == 0) begin
        chk1("start_one_cycle", start, 1'b0);
        chk1("busy_in_wait", busy, 1'b1);
      end
      if (k == d) begin
        done     = 1'b1;
        pe_we    = 1'b1;
        pe_wdata = res;
      end
    end
    @(negedge aclk);
    done  = 1'b0;
    pe_we = 1'b0;
    chk1("read_busy", busy, 1'b0 == 1'b0);
    chk1("read_terr_low", timeout_err, 1'b0);
    chk1("read_no_valid", out_valid, 1'b0);
    @(negedge aclk);
    chk1("capt_no_valid", out_valid, 1'b0);
    @(negedge aclk);
    chk1("out_valid_3_after_done", out_valid, 1'b1);
    chk32("out_data", out_data, res);
    chk1("in_ready_low_in_out", in_ready, 1'b0);
    chk32("start_pulsed_once", 32'(start_count - sc0), 32'd1);
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge aclk);
      chk1("out_valid_held", out_valid, 1'b1);
      chk32("out_data_stable", out_data, res);
    end
    out_ready = 1'b1;
    @(negedge aclk);
    out_ready = 1'b0;
    chk1("idle_out_valid_low", out_valid, 1'b0);
    chk1("idle_busy_low", busy, 1'b0);
    chk1("idle_in_ready_high", in_ready, 1'b1);
  endtask

  task automatic rand_words();
    for (int i = 0; i < NW; i++) exp_words[i] = $urandom;
  endtask

  initial begin
    int sc0;
    areset    = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    done      = 1'b0;
    out_ready = 1'b0;
    pe_we     = 1'b0;
    pe_wdata  = 32'h0;

    // Reset values.
    repeat (3) @(negedge aclk);
    areset = 1'b0;
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_start", start, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk32("rst_out_data", out_data, 32'h0);
    chk32("rst_bram_addr", BRAM_ADDR, 32'h0);
    chk32("rst_bram_wrdata", BRAM_WRDATA, 32'h0);
    chk32("rst_bram_we", {28'h0, BRAM_WE}, 32'h0);
    chk1("rst_bram_en", BRAM_EN, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_timeout_err", timeout_err, 1'b0);

    // Full-rate directed job: words 1..32, result 0x550, out_ready held off 5 cycles.
    for (int i = 0; i < NW; i++) exp_words[i] = 32'(i + 1);
    fill(0, 1'b0);
    finish_job(3, 32'h0000_0550, 5);

    // Gapped input with stray done pulses during fill (back-to-back job).
    rand_words();
    fill(1, 1'b1);
    finish_job($urandom_range(0, TO - 1), $urandom, 0);

    // Timeout: done never arrives.
    rand_words();
    fill(0, 1'b0);
    for (int k = 0; k < TO; k++) begin
      @(negedge aclk);
      if (k == TO - 1) begin
        chk1("wait_last_cycle_busy", busy, 1'b1);
        chk1("wait_last_cycle_terr", timeout_err, 1'b0);
      end
    end
    @(negedge aclk);
    chk1("timeout_busy_low", busy, 1'b0);
    chk1("timeout_err_set", timeout_err, 1'b1);
    chk1("timeout_no_result", out_valid, 1'b0);
    chk1("timeout_in_ready", in_ready, 1'b1);

    // Next job clears the flag; done coincides with expiry and wins.
    rand_words();
    fill(2, 1'b0);
    finish_job(TO - 1, $urandom, 2);

    // Reset mid-WAIT, stray done afterwards, then a fresh job.
    rand_words();
    fill(0, 1'b0);
    repeat (2) @(negedge aclk);
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    chk1("midwait_rst_busy", busy, 1'b0);
    chk1("midwait_rst_in_ready", in_ready, 1'b1);
    chk32("midwait_rst_out_data", out_data, 32'h0);
    sc0 = start_count;
    done = 1'b1;
    @(negedge aclk);
    done = 1'b0;
    @(negedge aclk);
    chk1("ignored_done_busy", busy, 1'b0);
    chk1("ignored_done_out_valid", out_valid, 1'b0);
    chk32("ignored_done_no_start", 32'(start_count - sc0), 32'd0);
    rand_words();
    fill(0, 1'b0);
    finish_job(1, $urandom, 1);

    // Randomized jobs.
    for (int j = 0; j < 3; j++) begin
      rand_words();
      fill(2, ($urandom_range(0, 1) == 1));
      finish_job($urandom_range(0, TO - 1), $urandom, $urandom_range(0, 4));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pe_host_seq.md
# pe_host_seq

Host-side sequencer for the PE controller's shared-BRAM/start/done protocol. It accepts a stream of 2·VECTOR_SIZE operand words, writes them into the shared BRAM through its own port, pulses `start` to the PE controller, waits for `done`, reads the 32-bit result back from word 0 and returns it on a valid/ready output. It sits between the upstream data source and the PE controller, on the opposite BRAM port from the controller.

## Interface
- VECTOR_SIZE, 16, elements per vector; BRAM words 0..VECTOR_SIZE-1 = global vector, VECTOR_SIZE..2·VECTOR_SIZE-1 = local vector
- L_RAM_SIZE, 4, log2(VECTOR_SIZE)
- TIMEOUT, 1024, max cycles spent in WAIT before abort
- aclk  in  1  sole clock; everything is on its rising edge
- areset  in  1  reset, synchronous, active-high
- in_data  in  32  operand word
- in_valid  in  1  operand word valid
- in_ready  out  1  sequencer accepts a word
- start  out  1  one-cycle pulse to the PE controller
- done  in  1  one-cycle completion pulse from the PE controller
- BRAM_ADDR  out  32  byte address, {word index, 2'b00}
- BRAM_WRDATA  out  32  write data
- BRAM_WE  out  4  byte write enables (4'hF or 0)
- BRAM_EN  out  1  port enable
- BRAM_RDDATA  in  32  read data, 1-cycle latency
- out_data  out  32  result word
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- busy  out  1  high in every state except IDLE
- timeout_err  out  1  sticky abort flag

## Operation
- States: IDLE, FILL, START, WAIT, READ, CAPT, OUT.
- IDLE: in_ready=1. A word accepted (in_valid&&in_ready) is written to word 0; widx←1; clear timeout_err; → FILL.
- FILL: in_ready=1. Each accepted word is written to word widx in the same cycle (BRAM_EN=1, BRAM_WE=4'hF, BRAM_WRDATA=in_data); widx increments. When the word at widx=2·VECTOR_SIZE-1 is accepted → START. No accept → hold, BRAM_EN=0.
- START: start=1 for exactly one cycle; load wait counter with 0 → WAIT.
- WAIT: count cycles. done=1 → READ. Counter reaches TIMEOUT-1 without done → set timeout_err, → IDLE; no result produced. If done and expiry coincide, done wins.
- READ: BRAM_ADDR=0, BRAM_EN=1, BRAM_WE=0 → CAPT.
- CAPT: out_data←BRAM_RDDATA → OUT.
- OUT: out_valid=1, out_data stable until out_valid&&out_ready → IDLE.
- done outside WAIT is ignored. in_ready=0 in START..OUT; upstream words are held off, not dropped.
- widx width is L_RAM_SIZE+1 bits. Wait counter is wide enough for TIMEOUT. BRAM_ADDR upper bits are zero.

## Timing
- Reset (areset=1 at an edge) in any state → IDLE next cycle; widx=0, counters=0. Outputs after reset: in_ready=1, start=0, out_valid=0, out_data=0, BRAM_ADDR=0, BRAM_WRDATA=0, BRAM_WE=0, BRAM_EN=0, busy=0, timeout_err=0. Reset mid-FILL discards partial data; reset in OUT drops the result.
- BRAM write and address are combinational from state and handshake in IDLE and FILL; the write happens on the accepting edge.
- Full-rate fill: the first word is accepted in cycle 0, the last in cycle 2·VECTOR_SIZE-1, and start is high in cycle 2·VECTOR_SIZE.
- Latency from done to out_valid is 3 cycles: done edge → READ, → CAPT, → OUT.
- Back-to-back jobs: the cycle after the OUT handshake, in_ready=1 again.

## Test plan
- Reset values: hold areset 3 cycles → all outputs at reset values listed above, in_ready=1.
- Full-rate job, VECTOR_SIZE=16: send words 1..32 continuously → BRAM word i holds i+1; start pulses once at cycle 32. Model writes 0x00000550 to word 0 and pulses done → out_valid 3 cycles later with out_data=0x00000550. Hold out_ready=0 for 5 cycles → data stable; then handshake → IDLE.
- Gapped input: toggle in_valid every cycle → exactly 32 writes, with no writes in gap cycles; start only after word 32.
- Timeout: TIMEOUT=8, never pulse done → 8 cycles after START, timeout_err=1 and state IDLE; the next accepted word clears timeout_err.
- Coincidence and stray done: done in the same cycle as timeout expiry → READ, timeout_err=0. done pulsed during FILL → ignored, and start still occurs after word 32.
- Reset mid-WAIT: assert areset → IDLE; a later done is ignored; a new 32-word job completes normally.
